// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART TX handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter; the master modport is the client plus UART side.
interface uart_tx_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ack;
   logic [NUM_REQ-1:0]            req_done;
   logic [DATA_WIDTH-1:0]         P_DATA_IN_TX;
   logic                          DATA_VALID_TX;
   logic                          busy_flag_TX;

   modport master (
      output req_valid, req_data, busy_flag_TX,
      input  req_ack, req_done, P_DATA_IN_TX, DATA_VALID_TX
   );

   modport slave (
      input  req_valid, req_data, busy_flag_TX,
      output req_ack, req_done, P_DATA_IN_TX, DATA_VALID_TX
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ requesters.
// Optional WAIT_BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = 2
`ifdef UART_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT    = 64
`endif
) (
   input  logic                 tx_clk,
   input  logic                 rst,
   uart_tx_arbiter_if.slave     bus,
   output logic [ID_W-1:0]      grant_id,
   output logic                 arb_busy,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
   logic [ID_W-1:0]        grant_q, grant_d;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   dv_q, dv_d;
   logic                   busy_q, busy_d;
   logic                   tmo_q, tmo_d;

   logic                   pick_hit;
   logic [ID_W-1:0]        pick_idx;
   logic [ID_W-1:0]        ptr_after_grant;
   logic                   tmo_hit;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] tmo_cnt_q;

   // Cleared while in ISSUE so it starts at zero on WAIT_BUSY entry.
   always_ff @(posedge tx_clk) begin
      if (rst)                         tmo_cnt_q <= '0;
      else if (state_q == S_ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == S_WAIT_BUSY) tmo_cnt_q <= tmo_cnt_q + 1'b1;
   end

   assign tmo_hit = (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   assign ptr_after_grant = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

   // State and registered-output flops.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge tx_clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         busy_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state logic, including the round-robin scan starting at ptr.
   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      pick_hit = 1'b0;
      pick_idx = '0;
      state_d  = state_q;

      // Scan from the far end so the slot nearest ptr wins last.
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         int slot;
         slot = int'(ptr_q) + off;
         if (slot >= NUM_REQ) slot = slot - NUM_REQ;
         if (bus.req_valid[slot]) begin
            pick_hit = 1'b1;
            pick_idx = ID_W'(slot);
         end
      end

      case (state_q)
         S_IDLE:      if (!bus.busy_flag_TX && pick_hit) state_d = S_ISSUE;
         S_ISSUE:     state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (bus.busy_flag_TX) state_d = S_WAIT_DONE;
            else if (tmo_hit)     state_d = S_IDLE;
         end
         S_WAIT_DONE: if (!bus.busy_flag_TX) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      ack_d   = '0;
      done_d  = '0;
      dv_d    = 1'b0;
      tmo_d   = 1'b0;
      data_d  = data_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      busy_d  = (state_d != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (!bus.busy_flag_TX && pick_hit) begin
               ack_d[pick_idx] = 1'b1;
               grant_d         = pick_idx;
               data_d          = bus.req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         S_ISSUE: dv_d = 1'b1;
         S_WAIT_BUSY: begin
            if (!bus.busy_flag_TX && tmo_hit) begin
               tmo_d = 1'b1;
               ptr_d = ptr_after_grant;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.busy_flag_TX) begin
               done_d[grant_q] = 1'b1;
               ptr_d           = ptr_after_grant;
            end
         end
         default: ;
      endcase
   end

   assign bus.req_ack       = ack_q;
   assign bus.req_done      = done_q;
   assign bus.P_DATA_IN_TX  = data_q;
   assign bus.DATA_VALID_TX = dv_q;
   assign grant_id          = grant_q;
   assign arb_busy          = busy_q;
   assign timeout_err       = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grant order, latency, busy gating, mid-frame reset
// and (with UART_ARB_TIMEOUT_EN) the watchdog.
module tb_uart_tx_arbiter;
   localparam int DW = 8;
   localparam int NR = 4;
   localparam int IW = 2;

   logic          tx_clk = 1'b0;
   logic          rst;
   logic [IW-1:0] grant_id;
   logic          arb_busy;
   logic          timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

   uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
      .tx_clk      (tx_clk),
      .rst         (rst),
      .bus         (bus.slave),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .timeout_err (timeout_err)
   );

   always #5 tx_clk = ~tx_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   // One complete frame starting in IDLE with requests already driven.
   task automatic run_frame(input string tag, input logic [NR-1:0] exp_oh,
                            input logic [IW-1:0] exp_id, input logic [DW-1:0] exp_word);
      tick();
      check({tag, " ack"},      32'(bus.req_ack), 32'(exp_oh));
      check({tag, " grant_id"}, 32'(grant_id), 32'(exp_id));
      check({tag, " dv early"}, 32'(bus.DATA_VALID_TX), 32'd0);
      bus.req_valid = bus.req_valid & ~bus.req_ack;
      tick();
      check({tag, " dv"},       32'(bus.DATA_VALID_TX), 32'd1);
      check({tag, " word"},     32'(bus.P_DATA_IN_TX), 32'(exp_word));
      check({tag, " ack once"}, 32'(bus.req_ack), 32'd0);
      tick();
      check({tag, " dv once"},  32'(bus.DATA_VALID_TX), 32'd0);
      bus.busy_flag_TX = 1'b1;
      tick();
      tick();
      check({tag, " done early"}, 32'(bus.req_done), 32'd0);
      check({tag, " arb_busy"},   32'(arb_busy), 32'd1);
      bus.busy_flag_TX = 1'b0;
      tick();
      check({tag, " done"},      32'(bus.req_done), 32'(exp_oh));
      check({tag, " idle"},      32'(arb_busy), 32'd0);
      check({tag, " no tmo"},    32'(timeout_err), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " ack"},      32'(bus.req_ack), 32'd0);
      check({tag, " done"},     32'(bus.req_done), 32'd0);
      check({tag, " dv"},       32'(bus.DATA_VALID_TX), 32'd0);
      check({tag, " word"},     32'(bus.P_DATA_IN_TX), 32'd0);
      check({tag, " grant_id"}, 32'(grant_id), 32'd0);
      check({tag, " arb_busy"}, 32'(arb_busy), 32'd0);
      check({tag, " tmo"},      32'(timeout_err), 32'd0);
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = '0;
      bus.req_data     = '0;
      bus.busy_flag_TX = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rst = 1'b0;

      // Single request from requester 2.
      bus.req_data  = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
      bus.req_valid = 4'b0100;
      run_frame("t1", 4'b0100, 2'd2, 8'hA5);

      // Fresh reset, then all four pending: served 0,1,2,3.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.req_valid = 4'b1111;
      run_frame("t2r0", 4'b0001, 2'd0, 8'h11);
      run_frame("t2r1", 4'b0010, 2'd1, 8'h22);
      run_frame("t2r2", 4'b0100, 2'd2, 8'h33);
      run_frame("t2r3", 4'b1000, 2'd3, 8'h44);
      tick();
      check("t2 no extra grant", 32'(bus.req_ack), 32'd0);

      // After req1, ptr=2: req3 wins over req0.
      bus.req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
      bus.req_valid = 4'b0010;
      run_frame("t3r1", 4'b0010, 2'd1, 8'hD1);
      bus.req_valid = 4'b1001;
      run_frame("t3r3", 4'b1000, 2'd3, 8'hD3);
      run_frame("t3r0", 4'b0001, 2'd0, 8'hD0);

      // UART busy in IDLE blocks the grant until it drops.
      bus.busy_flag_TX = 1'b1;
      bus.req_valid    = 4'b0001;
      tick();
      tick();
      tick();
      check("t4 ack blocked", 32'(bus.req_ack), 32'd0);
      check("t4 stays idle",  32'(arb_busy), 32'd0);
      bus.busy_flag_TX = 1'b0;
      run_frame("t4", 4'b0001, 2'd0, 8'hD0);

      // Reset in WAIT_DONE aborts the frame; ptr returns to 0.
      bus.req_data  = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
      bus.req_valid = 4'b0100;
      tick();
      check("t5 ack", 32'(bus.req_ack), 32'b0100);
      bus.req_valid = 4'b0000;
      tick();
      tick();
      bus.busy_flag_TX = 1'b1;
      tick();
      check("t5 in frame", 32'(arb_busy), 32'd1);
      rst = 1'b1;
      tick();
      check_all_zero("t5 rst");
      rst              = 1'b0;
      bus.busy_flag_TX = 1'b0;
      tick();
      check("t5 no done a", 32'(bus.req_done), 32'd0);
      tick();
      check("t5 no done b", 32'(bus.req_done), 32'd0);
      bus.req_valid = 4'b1001;
      run_frame("t5r0", 4'b0001, 2'd0, 8'hE0);
      run_frame("t5r3", 4'b1000, 2'd3, 8'hE3);

`ifdef UART_ARB_TIMEOUT_EN
      // Busy never rises: watchdog fires after 64 WAIT_BUSY cycles.
      bus.req_data  = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
      bus.req_valid = 4'b0110;
      tick();
      check("t6 ack", 32'(bus.req_ack), 32'b0010);
      bus.req_valid = bus.req_valid & ~bus.req_ack;
      tick();
      check("t6 dv", 32'(bus.DATA_VALID_TX), 32'd1);
      repeat (63) tick();
      check("t6 tmo early", 32'(timeout_err), 32'd0);
      check("t6 still busy", 32'(arb_busy), 32'd1);
      tick();
      check("t6 tmo", 32'(timeout_err), 32'd1);
      check("t6 no done", 32'(bus.req_done), 32'd0);
      check("t6 idle", 32'(arb_busy), 32'd0);
      run_frame("t6r2", 4'b0100, 2'd2, 8'hF2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
